// File: rtl/mem_access_controller_if.sv
// Command/response and RAM-port bundle for mem_access_controller.
// slave = the controller itself; master = CPU-side initiator plus RAM.
interface mem_access_controller_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_dst;
  logic [7:0]        cmd_len;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata, mem_data_out,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mem_address, mem_write_enable, mem_data_in
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata, mem_data_out,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mem_address, mem_write_enable, mem_data_in
  );
endinterface

// File: rtl/mem_access_controller.sv
// Sole master of the 256x8 synchronous data RAM: executes load, store and
// ascending block-copy commands and reports completion with a one-cycle pulse.
module mem_access_controller #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_access_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    CAP    = 3'd2,
    WR     = 3'd3,
    CP_RD  = 3'd4,
    CP_CAP = 3'd5,
    CP_WR  = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [7:0]        idx_nxt_s;

  assign idx_nxt_s = idx_q + 8'd1;

  // Next-state and next-output logic; RAM port values are staged one state ahead.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    idx_d       = idx_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    din_d       = din_q;
    we_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          src_d = bus.cmd_addr;
          dst_d = bus.cmd_dst;
          len_d = bus.cmd_len;
          idx_d = 8'd0;
          err_d = 1'b0;
          case (bus.cmd_op)
            2'b00: begin
              state_d = RD;
              addr_d  = bus.cmd_addr;
            end
            2'b01: begin
              state_d = WR;
              addr_d  = bus.cmd_addr;
              din_d   = bus.cmd_wdata;
              we_d    = 1'b1;
            end
            2'b10: begin
              if (bus.cmd_len == 8'd0) begin
                state_d = DONE;
              end else begin
                state_d = CP_RD;
                addr_d  = bus.cmd_addr;
              end
            end
            default: begin
              state_d = DONE;
              err_d   = 1'b1;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RD:     state_d = CAP;
      CAP: begin
        rdata_d = bus.mem_data_out;
        state_d = DONE;
      end
      WR:     state_d = DONE;
      CP_RD:  state_d = CP_CAP;
      CP_CAP: begin
        // The write-data register doubles as the one-byte copy buffer.
        din_d   = bus.mem_data_out;
        addr_d  = dst_q + ADDR_W'(idx_q);
        we_d    = 1'b1;
        state_d = CP_WR;
      end
      CP_WR: begin
        if (idx_q == len_q - 8'd1) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_nxt_s;
          addr_d  = src_q + ADDR_W'(idx_nxt_s);
          state_d = CP_RD;
        end
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Gating with reset keeps an aborting reset edge from committing a pending write.
  assign bus.mem_write_enable = we_q & ~reset;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data_in      = din_q;
  assign bus.cmd_ready        = (state_q == IDLE);
  assign bus.busy             = (state_q != IDLE);
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.rsp_rdata        = rdata_q;

endmodule
